// File: rtl/ht_weight_gen.sv
`default_nettype none
// ============================================================================
// Module   : ht_weight_gen
// Purpose  : Histogram front end for a Huffman coder. Counts occurrences of
//            each of 8 symbols over one frame (3-bit saturating counters),
//            then streams the 8 weights to the downstream Huffman stage and
//            waits for that stage to finish (code_valid high then low)
//            before accepting the next frame.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous reset, ACTIVE-HIGH despite the name
//            in_valid   - symbol strobe (ignored while in_ready=0)
//            in_symbol  - symbol index 0..7
//            in_last    - final symbol of the frame
//            in_mode    - code-output mode, sampled on first symbol
//            code_valid - downstream out_valid, used for frame completion
//            in_ready   - 1 = accepting symbols
//            out_valid  - weight strobe, 8 consecutive cycles per frame
//            out_weight - weight of symbol k on the k-th strobe cycle
//            out_mode   - latched mode, only on the first strobe cycle
// Revision : 1.0 - initial release
// ============================================================================
module ht_weight_gen (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [2:0] in_symbol,
   input  logic       in_last,
   input  logic       in_mode,
   input  logic       code_valid,
   output logic       in_ready,
   output logic       out_valid,
   output logic [2:0] out_weight,
   output logic       out_mode
);

   localparam int         NUM_SYMS = 8;
   localparam logic [2:0] CNT_MAX  = 3'd7;
   localparam logic [2:0] IDX_LAST = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COUNT   = 3'd1,
      S_GAP     = 3'd2,
      S_EMIT    = 3'd3,
      S_WAIT_HI = 3'd4,
      S_WAIT_LO = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q [NUM_SYMS];
   logic [2:0] cnt_d [NUM_SYMS];
   logic       mode_q, mode_d;
   logic [2:0] idx_q, idx_d;
   logic       in_ready_q, in_ready_d;
   logic       out_valid_q, out_valid_d;
   logic [2:0] out_weight_q, out_weight_d;
   logic       out_mode_q, out_mode_d;
   logic [2:0] idx_next;

   assign idx_next = idx_q + 3'd1;

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      idx_d        = idx_q;
      out_weight_d = 3'd0;
      out_mode_d   = 1'b0;
      for (int i = 0; i < NUM_SYMS; i++) begin
         cnt_d[i] = cnt_q[i];
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               // First symbol starts a fresh histogram.
               for (int i = 0; i < NUM_SYMS; i++) begin
                  cnt_d[i] = 3'd0;
               end
               cnt_d[in_symbol] = 3'd1;
               mode_d           = in_mode;
               state_d          = in_last ? S_GAP : S_COUNT;
            end
         end
         S_COUNT: begin
            if (in_valid) begin
               if (cnt_q[in_symbol] != CNT_MAX) begin
                  cnt_d[in_symbol] = cnt_q[in_symbol] + 3'd1;
               end
               if (in_last) begin
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            // Preload the first weight so it appears with the first strobe.
            state_d      = S_EMIT;
            idx_d        = 3'd0;
            out_weight_d = cnt_q[0];
            out_mode_d   = mode_q;
         end
         S_EMIT: begin
            // idx_q is the weight currently on the outputs; fetch the next.
            if (idx_q == IDX_LAST) begin
               state_d = S_WAIT_HI;
            end else begin
               idx_d        = idx_next;
               out_weight_d = cnt_q[idx_next];
            end
         end
         S_WAIT_HI: begin
            if (code_valid) begin
               state_d = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            if (!code_valid) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered outputs are derived from the next state so they line up
      // with the state they describe.
      out_valid_d = (state_d == S_EMIT);
      in_ready_d  = (state_d == S_IDLE) || (state_d == S_COUNT);
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q      <= S_IDLE;
         mode_q       <= 1'b0;
         idx_q        <= 3'd0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         out_weight_q <= 3'd0;
         out_mode_q   <= 1'b0;
         for (int i = 0; i < NUM_SYMS; i++) begin
            cnt_q[i] <= 3'd0;
         end
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         idx_q        <= idx_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_weight_q <= out_weight_d;
         out_mode_q   <= out_mode_d;
         for (int i = 0; i < NUM_SYMS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_weight = out_weight_q;
   assign out_mode   = out_mode_q;

endmodule
`default_nettype wire
